// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier.
//   state_e : controller states (IDLE, RUN, DONE)
//   digit_e : recoded Booth digit selected for one iteration
//   digit_is_neg() : true for digits that subtract a multiple
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,  // 0
        PM   = 3'd1,  // +M
        P2M  = 3'd2,  // +2M
        M2M  = 3'd3,  // -2M
        MM   = 3'd4   // -M
    } digit_e;

    function automatic logic digit_is_neg(input digit_e d);
        return (d == M2M) || (d == MM);
    endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// Radix-4 Booth triplet decode and multiple selection (combinational).
// Ports:
//   triplet_i : {q[1], q[0], q[-1]} of the current multiplier window
//   m_i       : multiplicand, already extended to WIDTH+2 bits
//   digit_o   : decoded Booth digit
//   mag_o     : magnitude of the selected multiple (0, M or 2M), sign-extended
//               to the WIDTH+4-bit upper accumulator width; the sign of the
//               digit is applied by the adder in the parent
module booth_digit_sel
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       triplet_i,
    input  logic [WIDTH+1:0] m_i,
    output digit_e           digit_o,
    output logic [WIDTH+3:0] mag_o
);

    digit_e           digit;
    logic [WIDTH+3:0] m_sx;

    always_comb begin
        digit = ZERO;
        case (triplet_i)
            3'b001, 3'b010: digit = PM;
            3'b011:         digit = P2M;
            3'b100:         digit = M2M;
            3'b101, 3'b110: digit = MM;
            default:        digit = ZERO;
        endcase

        m_sx = {{2{m_i[WIDTH+1]}}, m_i};

        mag_o = '0;
        case (digit)
            PM, MM:   mag_o = m_sx;
            P2M, M2M: mag_o = m_sx << 1;
            default:  mag_o = '0;
        endcase

        digit_o = digit;
    end

endmodule

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned operands.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : request a multiply (accepted in IDLE or DONE only)
//   signed_mode : 1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a, b        : multiplicand / multiplier (sampled with start)
//   busy        : high while iterating (RUN)
//   done        : one-cycle pulse when product becomes valid
//   product     : 2*WIDTH-bit result, held until the next accepted start
//   dbg_state   : current controller state
// Handshake: start is a level sampled on each rising edge; it is taken only
// when the controller is in IDLE or DONE and is silently dropped during RUN.
// done pulses for exactly one cycle, WIDTH/2+1 edges after the accepting edge.
module booth_radix4_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output state_e             dbg_state
);

    localparam int EW = WIDTH + 2;       // extended operand width
    localparam int UW = WIDTH + 4;       // upper accumulator half, holds +/-2M
    localparam int AW = UW + EW + 1;     // {upper, multiplier, guard bit}
    localparam int K  = WIDTH / 2 + 1;   // iterations
    localparam int CW = $clog2(K + 1);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [AW-1:0]      acc_q;
    logic [AW-1:0]      acc_d;
    logic [EW-1:0]      m_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;

    logic [EW-1:0]      a_ext;
    logic [EW-1:0]      b_ext;
    digit_e             digit;
    logic [UW-1:0]      mag;
    logic               neg;
    logic [UW-1:0]      sum;

    assign a_ext = {{2{signed_mode & a[WIDTH-1]}}, a};
    assign b_ext = {{2{signed_mode & b[WIDTH-1]}}, b};

    booth_digit_sel #(.WIDTH(WIDTH)) u_digit_sel (
        .triplet_i (acc_q[2:0]),
        .m_i       (m_q),
        .digit_o   (digit),
        .mag_o     (mag)
    );

    assign neg = digit_is_neg(digit);

    // The only adder: subtraction is invert-and-add-one on the multiple.
    // The whole {upper, multiplier, guard} register then shifts right by 2
    // with the upper half's sign bit replicated.
    always_comb begin
        sum   = acc_q[AW-1:EW+1] + (mag ^ {UW{neg}}) + UW'(neg);
        acc_d = $signed({sum, acc_q[EW:0]}) >>> 2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= a_ext;
                        acc_q   <= {{UW{1'b0}}, b_ext, 1'b0};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(K - 1)) begin
                        // After K double-shifts the multiplier bits are gone and
                        // the product sits just above the guard bit.
                        product_q <= acc_d[2*WIDTH:1];
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign product   = product_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
module tb_booth_radix4_mult;
    import booth_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-bit instance
    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] product8;
    state_e      state8;

    // 16-bit instance
    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] product16;
    state_e      state16;

    booth_radix4_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8),
        .product(product8), .dbg_state(state8)
    );

    booth_radix4_mult #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .busy(busy16), .done(done16),
        .product(product16), .dbg_state(state16)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers (called at posedge+1) ----------------
    task automatic go8(input logic sm, input logic [7:0] av, input logic [7:0] bv);
        sm8 = sm; a8 = av; b8 = bv; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (!done8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run8(input string tag, input logic sm, input logic [7:0] av,
                        input logic [7:0] bv, input logic [15:0] exp);
        int n;
        go8(sm, av, bv);
        check({tag, "_busy"}, 64'(busy8), 64'd1);
        wait_done8(n);
        check({tag, "_lat"}, 64'(n), 64'd5);
        check({tag, "_prod"}, 64'(product8), 64'(exp));
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, 64'(done8), 64'd0);
        check({tag, "_hold"}, 64'(product8), 64'(exp));
        check({tag, "_idle"}, 64'(state8), 64'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, k, pulses, first_k;
        logic [15:0] seen;
        logic sm;
        longint ax, bx;
        logic [31:0] e;

        #12;
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_prod", 64'(product8), 64'd0);
        check("rst_state", 64'(state8), 64'(IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // directed vectors
        run8("s_m128sq", 1'b1, 8'h80, 8'h80, 16'h4000);
        run8("u_ffff",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run8("s_ffff",   1'b1, 8'hFF, 8'hFF, 16'h0001);
        run8("s_127xm128", 1'b1, 8'h7F, 8'h80, 16'hC080);
        run8("u_200x100", 1'b0, 8'd200, 8'd100, 16'h4E20);
        run8("s_m1x127", 1'b1, 8'hFF, 8'h7F, 16'hFF81);
        run8("u_zero",   1'b0, 8'h00, 8'hA5, 16'h0000);

        // start re-pulsed during RUN is ignored
        go8(1'b0, 8'd7, 8'd9);
        k = 0; pulses = 0; first_k = 0; seen = '0;
        @(posedge clk); #1; k++;
        sm8 = 1'b0; a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
        @(posedge clk); #1; k++;
        start8 = 1'b0;
        if (done8) begin pulses++; first_k = k; seen = product8; end
        while (k < 12) begin
            @(posedge clk); #1; k++;
            if (done8) begin
                pulses++;
                if (pulses == 1) begin first_k = k; seen = product8; end
            end
        end
        check("ign_pulses", 64'(pulses), 64'd1);
        check("ign_lat", 64'(first_k), 64'd5);
        check("ign_prod", 64'(seen), 64'd63);

        // reset in the second RUN cycle
        go8(1'b0, 8'd7, 8'd9);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy8), 64'd0);
        check("mid_rst_prod", 64'(product8), 64'd0);
        check("mid_rst_done", 64'(done8), 64'd0);
        check("mid_rst_state", 64'(state8), 64'(IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done8) pulses++;
        end
        check("mid_rst_nodone", 64'(pulses), 64'd0);
        run8("s_5xm6", 1'b1, 8'd5, 8'hFA, 16'hFFE2);

        // start held in DONE: straight back into RUN
        go8(1'b0, 8'd2, 8'd3);
        wait_done8(n);
        check("b2b_lat1", 64'(n), 64'd5);
        check("b2b_prod1", 64'(product8), 64'd6);
        go8(1'b1, 8'hFD, 8'd7);
        check("b2b_state", 64'(state8), 64'(RUN));
        check("b2b_busy", 64'(busy8), 64'd1);
        check("b2b_done_low", 64'(done8), 64'd0);
        wait_done8(n);
        check("b2b_lat2", 64'(n), 64'd5);
        check("b2b_prod2", 64'(product8), 64'hFFEB);
        @(posedge clk); #1;

        // WIDTH=16 random operands against a reference product
        for (int i = 0; i < 1000; i++) begin
            sm = 1'($urandom_range(0, 1));
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            sm16 = sm;
            ax = sm ? longint'($signed(a16)) : longint'(a16);
            bx = sm ? longint'($signed(b16)) : longint'(b16);
            e = 32'(ax * bx);
            exp_q.push_back(e);
            start16 = 1'b1;
            @(posedge clk); #1;
            start16 = 1'b0;
            n = 0;
            while (!done16 && n < 30) begin
                @(posedge clk); #1;
                n++;
            end
            check("w16_lat", 64'(n), 64'd9);
            check("w16_prod", 64'(product16), 64'(exp_q.pop_front()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
